test_status_port: RTL and testbench
===================================

# test_status_port

Wishbone-slave status reporter in the user project area. Drives a parametrised stage code plus error flag onto user I/O so the testbench monitor can follow firmware self-test progress. Generalises the fixed 5-bit stage / 1-bit error scheme with configurable stage width, a hardware watchdog that flags stalled tests, and a stage-history FIFO readable over Wishbone.

## Interface
- STAGE_W, 5: stage code width; status_o is STAGE_W+1 bits.
- TIMEOUT_W, 20: watchdog counter width.
- HIST_DEPTH, 8: history FIFO entries; power of two, 2..64.

- wb_clk_i  in  1  sole clock; all state on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic controls.
- wbs_sel_i  in  4  byte lanes; writes honour lanes 0, 2, 3; lane 1 ignored.
- wbs_adr_i  in  32  only bits [3:2] decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data, valid with ack, 0 otherwise.
- status_o  out  STAGE_W+1  {error, stage}; error is MSB.
- status_oeb  out  STAGE_W+1  constant 0 (always driven).
- timeout_o  out  1  sticky watchdog expiry.

## Operation
- Registers (adr[3:2]):
  - 0 STAGE: W [STAGE_W-1:0] stage, bit 31 = 1 sets sticky error (0 has no effect). R {error_flag, 0..., stage}.
  - 1 TIMEOUT: W/R reload value [TIMEOUT_W-1:0]; 0 disables watchdog.
  - 2 HIST: R pops oldest entry: bit 31 valid, [STAGE_W-1:0] stage; empty read returns 0, no state change. Writes ignored.
  - 3 STATUS: R bit0 overflow, bit1 timeout, bit2 full, bit3 empty, [15:8] count. W bit0=1 clears overflow, bit1=1 clears timeout and reloads watchdog.
- STAGE write with stage different from current: update stage, push new stage into FIFO, reload watchdog. Same stage: no push, watchdog reloaded (kick).
- Push when full: entry dropped, overflow set; FIFO contents unchanged.
- Pointers wrap modulo HIST_DEPTH; count range 0..HIST_DEPTH.
- Watchdog: counter loaded with TIMEOUT on reload; decrements each cycle while nonzero and TIMEOUT≠0; transition 1→0 sets timeout. Holds at 0.
- Error output = error_flag | timeout. error_flag cleared only by reset.
- Reset: stage 0, error_flag 0, TIMEOUT 0, counter 0, FIFO empty, overflow 0, timeout 0, wbs_ack_o 0, wbs_dat_o 0, status_o 0.

## Timing
- Access accepted when cyc&stb&!ack; ack high exactly one cycle on next edge, then low at least one cycle (no back-to-back acks). One access per two cycles max, so push and pop never coincide.
- Register writes, FIFO pop and status_o update on the same edge that raises ack.
- timeout_o rises exactly T edges after the reload edge (T = TIMEOUT value); a kick on edge T-1 or earlier prevents it.
- Timeout clear and expiry on the same edge: clear wins, counter reloaded.
- Reset mid-transaction: ack drops immediately (async); pending access discarded.
- Reset release: first access accepted on the first edge with reset low.

## Configuration
- TEST_STATUS_HISTORY_EN defined: FIFO, HIST register and overflow/full/count fields as above.
- Undefined: no FIFO storage; HIST reads return 0; STATUS bits 0, 2 read 0, bit3 reads 1, count reads 0; overflow never sets. Stage, error and watchdog unchanged.

## Test plan
- Reset, write STAGE=31 -> status_o=6'h1F one cycle after stb; HIST read -> 0x8000001F, then 0x00000000.
- Write STAGE 0,1,2 then bit31=1 with stage 2 -> status_o=6'h22; STAGE read 0x80000002; HIST pops 0,1,2 (valid), no extra push for repeated 2.
- HIST_DEPTH=8: nine distinct stage writes -> STATUS full=1, overflow=1, count=8; pops return first eight in order; clear overflow via STATUS W 0x1 -> bit0 reads 0.
- TIMEOUT=100, write STAGE=3, no further access -> timeout_o rises exactly 100 edges later, status_o MSB=1; kick at edge 99 in repeat run -> no timeout.
- Timeout set, STATUS W 0x2 -> timeout_o and MSB low (error_flag 0), watchdog restarts from 100.
- Assert wb_rst_i asynchronously during ack cycle -> ack, status_o, timeout_o all 0 before next edge; FIFO empty after release.

Source files
------------

// File: rtl/test_status_port.sv
// Wishbone status reporter: drives {error, stage} onto user I/O, with a stall watchdog and
// an optional stage-history FIFO enabled by defining TEST_STATUS_HISTORY_EN.
module test_status_port #(
  parameter int STAGE_W    = 5,
  parameter int TIMEOUT_W  = 20,
  parameter int HIST_DEPTH = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [STAGE_W:0]   status_o,
  output logic [STAGE_W:0]   status_oeb,
  output logic               timeout_o
);

  logic                 ack_reg;
  logic [31:0]          dat_reg;
  logic [STAGE_W-1:0]   stage_reg;
  logic                 error_flag_reg;
  logic [TIMEOUT_W-1:0] reload_reg, reload_next;
  logic [TIMEOUT_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic                 timeout_reg, timeout_next;

  logic                 access, wr_en, rd_en;
  logic [1:0]           addr;
  logic [STAGE_W-1:0]   new_stage;
  logic                 stage_wr, stage_change, err_set, tmo_wr;
  logic                 stat_wr, clr_ovf, clr_tmo, wd_reload, hist_rd;
  logic                 overflow_flag, fifo_full, fifo_empty;
  logic [7:0]           fifo_count;
  logic [31:0]          hist_word;
  logic [31:0]          rdata;
  logic                 unused_ok;

  // An access is taken only while ack is low, which forces a dead cycle between accesses.
  assign access       = wbs_cyc_i & wbs_stb_i & ~ack_reg;
  assign wr_en        = access & wbs_we_i;
  assign rd_en        = access & ~wbs_we_i;
  assign addr         = wbs_adr_i[3:2];
  assign new_stage    = wbs_dat_i[STAGE_W-1:0];
  assign stage_wr     = wr_en && (addr == 2'd0) && wbs_sel_i[0];
  assign stage_change = stage_wr && (new_stage != stage_reg);
  assign err_set      = wr_en && (addr == 2'd0) && wbs_sel_i[3] && wbs_dat_i[31];
  assign tmo_wr       = wr_en && (addr == 2'd1);
  assign stat_wr      = wr_en && (addr == 2'd3) && wbs_sel_i[0];
  assign clr_ovf      = stat_wr & wbs_dat_i[0];
  assign clr_tmo      = stat_wr & wbs_dat_i[1];
  assign wd_reload    = stage_wr | clr_tmo;
  assign hist_rd      = rd_en && (addr == 2'd2);

  // Byte-lane merge for the reload value; lane 1 is never writable.
  generate
    for (genvar gi = 0; gi < TIMEOUT_W; gi++) begin : g_reload_lane
      localparam int LANE = gi / 8;
      if (LANE == 1) begin : g_keep
        assign reload_next[gi] = reload_reg[gi];
      end else begin : g_write
        assign reload_next[gi] = (tmo_wr && wbs_sel_i[LANE]) ? wbs_dat_i[gi] : reload_reg[gi];
      end
    end
  endgenerate

`ifdef TEST_STATUS_HISTORY_EN
  localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [STAGE_W-1:0] hist_mem [HIST_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               overflow_reg;
  logic               push, pop;

  assign fifo_full     = (count_reg == CNT_W'(HIST_DEPTH));
  assign fifo_empty    = (count_reg == '0);
  assign push          = stage_change & ~fifo_full;
  assign pop           = hist_rd & ~fifo_empty;
  assign fifo_count    = 8'(count_reg);
  assign overflow_flag = overflow_reg;

  always_ff @(posedge wb_clk_i) begin
    if (push) hist_mem[wr_ptr_reg] <= new_stage;
  end

  // Pointers are power-of-two wide, so they wrap without explicit compare.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push)     count_reg <= count_reg + 1'b1;
      else if (pop) count_reg <= count_reg - 1'b1;
      if (stage_change && fifo_full) overflow_reg <= 1'b1;
      else if (clr_ovf)              overflow_reg <= 1'b0;
    end
  end

  always_comb begin
    hist_word = '0;
    if (!fifo_empty) begin
      hist_word[31]          = 1'b1;
      hist_word[STAGE_W-1:0] = hist_mem[rd_ptr_reg];
    end
  end
`else
  logic unused_hist;

  assign fifo_full     = 1'b0;
  assign fifo_empty    = 1'b1;
  assign fifo_count    = '0;
  assign overflow_flag = 1'b0;
  assign hist_word     = '0;
  assign unused_hist   = ^{hist_rd, stage_change, clr_ovf, (HIST_DEPTH > 0)};
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: begin
        rdata[31]          = error_flag_reg;
        rdata[STAGE_W-1:0] = stage_reg;
      end
      2'd1:    rdata[TIMEOUT_W-1:0] = reload_reg;
      2'd2:    rdata = hist_word;
      default: begin
        rdata[0]    = overflow_flag;
        rdata[1]    = timeout_reg;
        rdata[2]    = fifo_full;
        rdata[3]    = fifo_empty;
        rdata[15:8] = fifo_count;
      end
    endcase
  end

  // Reload beats decrement, so a kick on the expiry edge still prevents the timeout.
  always_comb begin
    wd_cnt_next  = wd_cnt_reg;
    timeout_next = timeout_reg;
    if (wd_reload) begin
      wd_cnt_next = reload_reg;
    end else if ((wd_cnt_reg != '0) && (reload_reg != '0)) begin
      wd_cnt_next = wd_cnt_reg - 1'b1;
      if (wd_cnt_reg == TIMEOUT_W'(1)) timeout_next = 1'b1;
    end
    if (clr_tmo) timeout_next = 1'b0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_reg        <= 1'b0;
      dat_reg        <= '0;
      stage_reg      <= '0;
      error_flag_reg <= 1'b0;
      reload_reg     <= '0;
      wd_cnt_reg     <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      ack_reg     <= access;
      dat_reg     <= rd_en ? rdata : '0;
      if (stage_wr) stage_reg <= new_stage;
      if (err_set)  error_flag_reg <= 1'b1;
      reload_reg  <= reload_next;
      wd_cnt_reg  <= wd_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign wbs_ack_o  = ack_reg;
  assign wbs_dat_o  = dat_reg;
  assign status_o   = {error_flag_reg | timeout_reg, stage_reg};
  assign status_oeb = '0;
  assign timeout_o  = timeout_reg;
  assign unused_ok  = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

endmodule

// File: tb/tb_test_status_port.sv
// Testbench for test_status_port: directed scenarios plus randomized traffic checked against
// a queue-based model; follows TEST_STATUS_HISTORY_EN the same way as the design.
module tb_test_status_port;
  localparam int STAGE_W    = 5;
  localparam int TIMEOUT_W  = 20;
  localparam int HIST_DEPTH = 8;
`ifdef TEST_STATUS_HISTORY_EN
  localparam bit HIST_EN = 1'b1;
`else
  localparam bit HIST_EN = 1'b0;
`endif

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b0;
  logic              wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]        wbs_sel_i = 4'h0;
  logic [31:0]       wbs_adr_i = '0, wbs_dat_i = '0;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [STAGE_W:0]  status_o, status_oeb;
  logic              timeout_o;

  int cycle = 0;
  int n_checks = 0;
  int n_fail = 0;

  test_status_port #(.STAGE_W(STAGE_W), .TIMEOUT_W(TIMEOUT_W), .HIST_DEPTH(HIST_DEPTH)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .status_o(status_o), .status_oeb(status_oeb), .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cycle <= cycle + 1;

  // Reference model: registers as plain values, history as a queue, and the watchdog as
  // "last reload edge + reload value" instead of a cycle-by-cycle counter.
  logic [4:0]  m_stage;
  bit          m_err, m_ovf, m_sticky;
  logic [31:0] m_tov;
  logic [4:0]  m_q[$];
  int          m_rl_edge, m_rl_val;

  task automatic model_reset();
    m_stage = '0; m_err = 0; m_ovf = 0; m_sticky = 0; m_tov = '0;
    m_q.delete(); m_rl_edge = 0; m_rl_val = 0;
  endtask

  function automatic bit tm(input int t);
    return m_sticky || (m_rl_val != 0 && t >= m_rl_edge + m_rl_val);
  endfunction

  function automatic logic [5:0] exp_status(input int t);
    return {m_err | tm(t), m_stage};
  endfunction

  task automatic model_reload(input int e);
    if (m_rl_val != 0 && m_rl_edge + m_rl_val < e) m_sticky = 1;
    m_rl_edge = e;
    m_rl_val  = int'(m_tov);
  endtask

  task automatic model_step(input bit w, input logic [1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int e, output logic [31:0] ex);
    logic [31:0] t;
    ex = '0;
    if (!w) begin
      case (a)
        2'd0: ex = {m_err, 26'd0, m_stage};
        2'd1: ex = m_tov;
        2'd2: if (HIST_EN && m_q.size() > 0) ex = 32'h8000_0000 | 32'(m_q.pop_front());
        default: begin
          ex[0]    = m_ovf;
          ex[1]    = tm(e - 1);
          ex[2]    = HIST_EN && (m_q.size() == HIST_DEPTH);
          ex[3]    = (m_q.size() == 0);
          ex[15:8] = 8'(m_q.size());
        end
      endcase
    end else begin
      case (a)
        2'd0: begin
          if (s[0]) begin
            if (d[4:0] != m_stage) begin
              m_stage = d[4:0];
              if (HIST_EN) begin
                if (m_q.size() == HIST_DEPTH) m_ovf = 1;
                else m_q.push_back(d[4:0]);
              end
            end
            model_reload(e);
          end
          if (s[3] && d[31]) m_err = 1;
        end
        2'd1: begin
          t = m_tov;
          if (s[0]) t[7:0]   = d[7:0];
          if (s[2]) t[23:16] = d[23:16];
          if (s[3]) t[31:24] = d[31:24];
          m_tov = t & 32'h000F_FFFF;
        end
        2'd3: if (s[0]) begin
          if (d[0]) m_ovf = 0;
          if (d[1]) begin m_sticky = 0; m_rl_edge = e; m_rl_val = int'(m_tov); end
        end
        default: ;
      endcase
    end
  endtask

  // One bus access; returns the observed read data, the model's expectation and the ack edge.
  task automatic xact(input bit w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic [31:0] ex, output int ae);
    bit got = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = w;
    wbs_adr_i = {28'd0, a, 2'b00}; wbs_dat_i = d; wbs_sel_i = s;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin got = 1; break; end
    end
    ae = cycle; rd = wbs_dat_o;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL ack_wait: got no ack, want ack within 8 edges"); end
    model_step(w, a, d, s, ae, ex);
    $display("xact we=%0d adr=%0d dat=%h sel=%h rd=%h exp=%h edge=%0d status=%h",
             w, a, d, s, rd, ex, ae, status_o);
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] rd, ex; int ae;
    do_reset();
    n_checks++; if (wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", wbs_ack_o); end
    n_checks++; if (wbs_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", wbs_dat_o); end
    n_checks++; if (status_o !== 6'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", status_o); end
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    n_checks++; if (status_oeb !== 6'h00) begin n_fail++; $display("FAIL status_oeb: got %h want 00", status_oeb); end
    xact(0, 2'd3, 0, 4'hF, rd, ex, ae);
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL reset_statreg: got %h want 00000008", rd); end
  endtask

  task automatic test_stage_history();
    logic [31:0] rd, ex; int ae;
    logic [31:0] seq [4] = '{32'd0, 32'd1, 32'd2, 32'h8000_0002};
    xact(1, 2'd0, 32'd31, 4'hF, rd, ex, ae);
    n_checks++; if (status_o !== 6'h1F) begin n_fail++; $display("FAIL stage31_status: got %h want 1f", status_o); end
    for (int i = 0; i < 2; i++) begin
      xact(0, 2'd2, 0, 4'hF, rd, ex, ae);
      n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL hist31_pop%0d: got %h want %h", i, rd, ex); end
    end
    for (int i = 0; i < 4; i++) xact(1, 2'd0, seq[i], 4'hF, rd, ex, ae);
    n_checks++; if (status_o !== 6'h22) begin n_fail++; $display("FAIL err_status: got %h want 22", status_o); end
    xact(0, 2'd0, 0, 4'hF, rd, ex, ae);
    n_checks++; if (rd !== 32'h8000_0002) begin n_fail++; $display("FAIL stage_read: got %h want 80000002", rd); end
    for (int i = 0; i < 4; i++) begin
      xact(0, 2'd2, 0, 4'hF, rd, ex, ae);
      n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL hist_pop%0d: got %h want %h", i, rd, ex); end
    end
  endtask

  task automatic test_history_overflow();
    logic [31:0] rd, ex; int ae;
    do_reset();
    for (int i = 1; i <= 9; i++) xact(1, 2'd0, 32'(i), 4'hF, rd, ex, ae);
    xact(0, 2'd3, 0, 4'hF, rd, ex, ae);
    n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL ovf_status: got %h want %h", rd, ex); end
    for (int i = 0; i < 9; i++) begin
      xact(0, 2'd2, 0, 4'hF, rd, ex, ae);
      n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL ovf_pop%0d: got %h want %h", i, rd, ex); end
    end
    xact(1, 2'd3, 32'h1, 4'hF, rd, ex, ae);
    xact(0, 2'd3, 0, 4'hF, rd, ex, ae);
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000008", rd); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, ex; int ae;
    do_reset();
    xact(1, 2'd1, 32'hFFFF_FFFF, 4'b0010, rd, ex, ae);
    xact(0, 2'd1, 0, 4'hF, rd, ex, ae);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL lane1_only: got %h want 0", rd); end
    xact(1, 2'd1, 32'h000A_FF64, 4'hF, rd, ex, ae);
    xact(0, 2'd1, 0, 4'hF, rd, ex, ae);
    n_checks++; if (rd !== 32'h000A_0064) begin n_fail++; $display("FAIL tmo_lanes: got %h want 000a0064", rd); end
    xact(1, 2'd0, 32'h8000_0007, 4'b0111, rd, ex, ae);
    n_checks++; if (status_o !== 6'h07) begin n_fail++; $display("FAIL err_lane_off: got %h want 07", status_o); end
    xact(1, 2'd0, 32'h8000_0009, 4'b1000, rd, ex, ae);
    n_checks++; if (status_o !== 6'h27) begin n_fail++; $display("FAIL err_lane_only: got %h want 27", status_o); end
  endtask

  task automatic test_watchdog();
    logic [31:0] rd, ex; int ae, ke;
    do_reset();
    xact(1, 2'd1, 32'd100, 4'hF, rd, ex, ae);
    xact(1, 2'd0, 32'd3, 4'hF, rd, ex, ae);
    n_checks++; if (status_o !== 6'h03) begin n_fail++; $display("FAIL wd_start: got %h want 03", status_o); end
    repeat (99) @(posedge wb_clk_i); #1;
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL wd_edge99: got %b want 0", timeout_o); end
    @(posedge wb_clk_i); #1;
    n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL wd_edge100: got %b want 1", timeout_o); end
    n_checks++; if (status_o !== 6'h23) begin n_fail++; $display("FAIL wd_status: got %h want 23", status_o); end
    // Repeat with a kick landing on edge 99.
    do_reset();
    xact(1, 2'd1, 32'd100, 4'hF, rd, ex, ae);
    xact(1, 2'd0, 32'd3, 4'hF, rd, ex, ae);
    repeat (98) @(posedge wb_clk_i); #1;
    xact(1, 2'd0, 32'd3, 4'hF, rd, ex, ke);
    n_checks++; if (ke !== ae + 99) begin n_fail++; $display("FAIL kick_edge: got %0d want %0d", ke - ae, 99); end
    @(posedge wb_clk_i); #1;
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL kick_edge100: got %b want 0", timeout_o); end
    repeat (98) @(posedge wb_clk_i); #1;
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL kick_late99: got %b want 0", timeout_o); end
    @(posedge wb_clk_i); #1;
    n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL kick_late100: got %b want 1", timeout_o); end
  endtask

  task automatic test_timeout_clear();
    logic [31:0] rd, ex; int ae;
    xact(1, 2'd3, 32'h2, 4'hF, rd, ex, ae);
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL clr_timeout: got %b want 0", timeout_o); end
    n_checks++; if (status_o !== 6'h03) begin n_fail++; $display("FAIL clr_status: got %h want 03", status_o); end
    repeat (99) @(posedge wb_clk_i); #1;
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL clr_edge99: got %b want 0", timeout_o); end
    @(posedge wb_clk_i); #1;
    n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL clr_edge100: got %b want 1", timeout_o); end
  endtask

  task automatic test_random();
    logic [31:0] rd, ex, d; int ae, k;
    do_reset();
    xact(1, 2'd1, 32'($urandom_range(20, 60)), 4'hF, rd, ex, ae);
    for (int n = 0; n < 200; n++) begin
      k = int'($urandom % 8);
      case (k)
        0, 1, 2: begin
          d = 32'($urandom_range(0, 3));
          if ($urandom % 40 == 0) d[31] = 1'b1;
          xact(1, 2'd0, d, 4'hF, rd, ex, ae);
        end
        3: xact(0, 2'd2, 0, 4'hF, rd, ex, ae);
        4: xact(0, 2'd0, 0, 4'hF, rd, ex, ae);
        5: xact(0, 2'd3, 0, 4'hF, rd, ex, ae);
        6: xact(1, 2'd3, 32'($urandom % 4), 4'hF, rd, ex, ae);
        default: begin
          repeat ($urandom_range(1, 40)) @(posedge wb_clk_i); #1;
          rd = '0; ex = '0;
          $display("idle until edge=%0d status=%h timeout=%b", cycle, status_o, timeout_o);
        end
      endcase
      n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL rnd_rdata op%0d: got %h want %h", n, rd, ex); end
      n_checks++; if (status_o !== exp_status(cycle)) begin n_fail++; $display("FAIL rnd_status op%0d: got %h want %h", n, status_o, exp_status(cycle)); end
      n_checks++; if (timeout_o !== tm(cycle)) begin n_fail++; $display("FAIL rnd_timeout op%0d: got %b want %b", n, timeout_o, tm(cycle)); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd, ex; int ae, rel;
    do_reset();
    xact(1, 2'd1, 32'd5, 4'hF, rd, ex, ae);
    xact(1, 2'd0, 32'd4, 4'hF, rd, ex, ae);
    repeat (6) @(posedge wb_clk_i); #1;
    n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL pre_reset_timeout: got %b want 1", timeout_o); end
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h0; wbs_dat_i = 32'd9; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    $display("xact we=1 adr=0 dat=%h sel=f interrupted by reset edge=%0d", wbs_dat_i, cycle);
    n_checks++; if (wbs_ack_o !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ack: got %b want 1", wbs_ack_o); end
    #1 wb_rst_i = 1;
    #1;
    n_checks++; if (wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL async_ack: got %b want 0", wbs_ack_o); end
    n_checks++; if (status_o !== 6'h00) begin n_fail++; $display("FAIL async_status: got %h want 00", status_o); end
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL async_timeout: got %b want 0", timeout_o); end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 0; rel = cycle; model_reset();
    xact(0, 2'd3, 0, 4'hF, rd, ex, ae);
    n_checks++; if (ae !== rel + 1) begin n_fail++; $display("FAIL first_access: got edge %0d want %0d", ae, rel + 1); end
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL post_reset_empty: got %h want 00000008", rd); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stage_history();
    test_history_overflow();
    test_byte_lanes();
    test_watchdog();
    test_timeout_clear();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, want finish before 2ms");
    $fatal(1, "simulation time limit");
  end
endmodule
